// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor; ovf exists only with SERIAL_SUB_OVF_EN.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             busy;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, busy
`ifdef SERIAL_SUB_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, busy
`ifdef SERIAL_SUB_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one full-subtractor cell; SERIAL_SUB_OVF_EN adds signed overflow.
// Latency: accept edge plus WIDTH shift edges, result then held in DONE; one op per WIDTH+2 cycles.
// Backpressure: result held with out_valid until out_ready; no new operands taken until then.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             ovf_q, ovf_d;
`endif

    logic last_bit;
    logic d_bit;
    logic br_next;

    assign last_bit = (cnt_q == CW'(WIDTH - 1));
    assign d_bit    = a_q[0] ^ b_q[0] ^ br_q;
    assign br_next  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.in_valid)  state_d = S_SHIFT;
            S_SHIFT: if (last_bit)      state_d = S_DONE;
            S_DONE:  if (bus.out_ready) state_d = S_IDLE;
            default:                    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == S_IDLE);
        bus.out_valid = (state_q == S_DONE);
        bus.busy      = (state_q != S_IDLE);
        bus.diff      = diff_q;
        bus.bout      = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        bus.ovf       = ovf_q;
`endif
    end

    // Published result registers only change on the final shift, so diff/bout hold through DONE and IDLE.
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        res_d  = res_q;
        br_d   = br_q;
        cnt_d  = cnt_q;
        diff_d = diff_q;
        bout_d = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d   = bus.a;
                    b_d   = bus.b;
                    br_d  = bus.bin;
                    res_d = '0;
                    cnt_d = '0;
`ifdef SERIAL_SUB_OVF_EN
                    a_msb_d = bus.a[WIDTH-1];
                    b_msb_d = bus.b[WIDTH-1];
`endif
                end
            end
            S_SHIFT: begin
                a_d   = {1'b0, a_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                res_d = {d_bit, res_q[WIDTH-1:1]};
                br_d  = br_next;
                cnt_d = cnt_q + 1'b1;
                if (last_bit) begin
                    diff_d = {d_bit, res_q[WIDTH-1:1]};
                    bout_d = br_next;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d  = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            br_q   <= 1'b0;
            cnt_q  <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            res_q  <= res_d;
            br_q   <= br_d;
            cnt_q  <= cnt_d;
            diff_q <= diff_d;
            bout_q <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end
endmodule
